// File: rtl/cnn_pkg.sv
// Shared widths, kernel geometry, descriptor layout and FSM encoding for the
// multi-layer 5x5 convolution sequencer.
package cnn_pkg;

    localparam int unsigned DW          = 16;
    localparam int unsigned K           = 5;
    localparam int unsigned KK          = K * K;
    localparam int unsigned MAX_IMG     = 32;
    localparam int unsigned MAX_PIX     = MAX_IMG * MAX_IMG;
    localparam int unsigned FRAC        = 8;
    localparam int unsigned ACC_W       = 32;
    localparam int unsigned IDX_W       = $clog2(MAX_PIX);
    localparam int unsigned TAP_W       = $clog2(KK);
    localparam int unsigned SUB_W       = $clog2(K);

    // Descriptor layout: word0 holds the layer count, filters follow back to back.
    localparam int unsigned HDR_OFFSET  = 0;
    localparam int unsigned FILT_OFFSET = 1;

    typedef enum logic [2:0] {
        IDLE,
        RD_HDR,
        RD_FILT,
        LD_IMG,
        MAC,
        WR,
        NEXT,
        DONE
    } state_t;

endpackage

// File: rtl/cnn_mac.sv
// Serial multiply-accumulate: one signed 16x16 product per step into a wrapping
// 32-bit accumulator, with the Q8.8 slice of the post-step sum exposed.
module cnn_mac
    import cnn_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 step,
    input  logic signed [DW-1:0] pixel,
    input  logic signed [DW-1:0] weight,
    output logic signed [DW-1:0] resultNext_c
);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] product;
    logic signed [ACC_W-1:0] accNext;

    assign product      = ACC_W'(pixel) * ACC_W'(weight);
    assign accNext      = acc + product;
    // Lets the controller register the final pixel value on the same edge as the last tap.
    assign resultNext_c = accNext[FRAC+DW-1:FRAC];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (step) begin
            acc <= accNext;
        end
    end

endmodule

// File: rtl/cnn_controller.sv
// Layer sequencer: reads descriptor and filters over DMA, has load_block fetch each
// image, runs a serial 5x5 valid convolution and writes every output pixel back.
module cnn_controller
    import cnn_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [DW-1:0]        orgLayerAddress,
    input  logic [DW-1:0]        orgImgAddress,
    input  logic [DW-1:0]        orgImgSize,
    input  logic signed [DW-1:0] memFetchResult [KK],
    input  logic signed [DW-1:0] fetchedImage [MAX_PIX],
    input  logic [DW-1:0]        loadBlockAddress,
    input  logic                 dmaDone,
    input  logic                 loadImageDone,
    output logic [DW-1:0]        imgSize,
    output logic                 dmaEnable,
    output logic [DW-1:0]        dmaAddress,
    output logic signed [DW-1:0] dmaInput,
    output logic                 loadEnable,
    output logic                 writeEnable,
    output logic                 loadImageEnable,
    output logic [DW-1:0]        loadImgAddress,
    output logic                 done
);

    state_t state, stateNext;

    logic [DW-1:0]        layerIdx, layerIdxNext;
    logic [DW-1:0]        numLayers, numLayersNext;
    logic [DW-1:0]        curImg, curImgNext;
    logic [DW-1:0]        outAddr, outAddrNext;
    logic [DW-1:0]        row, rowNext;
    logic [DW-1:0]        col, colNext;
    logic [DW-1:0]        imgSizeNext;
    logic [TAP_W-1:0]     tap, tapNext;
    logic [SUB_W-1:0]     tapRow, tapRowNext;
    logic [SUB_W-1:0]     tapCol, tapColNext;
    logic [DW-1:0]        dmaAddressNext, loadImgAddressNext;
    logic signed [DW-1:0] dmaInputNext;
    logic                 loadEnableNext, writeEnableNext, loadImageEnableNext, doneNext;

    logic signed [DW-1:0] weights [KK];
    logic                 loadWeights, macClear, macStep;
    logic [DW-1:0]        outSide, lastIdx;
    logic [IDX_W-1:0]     pixIdx;
    logic signed [DW-1:0] pixelResult;
    logic                 unusedLoadBlock;

    assign unusedLoadBlock = ^loadBlockAddress;

    assign outSide = imgSize - DW'(K - 1);
    assign lastIdx = imgSize - DW'(K);
    assign pixIdx  = IDX_W'((row + DW'(tapRow)) * imgSize + col + DW'(tapCol));

    cnn_mac u_mac (
        .clk          (clk),
        .reset        (reset),
        .clear        (macClear),
        .step         (macStep),
        .pixel        (fetchedImage[pixIdx]),
        .weight       (weights[tap]),
        .resultNext_c (pixelResult)
    );

    // Next-state, counter updates and registered-output values; busy states hold while enable is low.
    always_comb begin
        stateNext     = state;
        layerIdxNext  = layerIdx;
        numLayersNext = numLayers;
        curImgNext    = curImg;
        outAddrNext   = outAddr;
        rowNext       = row;
        colNext       = col;
        imgSizeNext   = imgSize;
        tapNext       = tap;
        tapRowNext    = tapRow;
        tapColNext    = tapCol;
        loadWeights   = 1'b0;
        macClear      = 1'b0;
        macStep       = 1'b0;

        case (state)
            IDLE: if (enable) begin
                curImgNext   = orgImgAddress;
                imgSizeNext  = orgImgSize;
                layerIdxNext = '0;
                stateNext    = RD_HDR;
            end
            RD_HDR: if (enable && loadEnable && dmaDone) begin
                numLayersNext = memFetchResult[0];
                if (memFetchResult[0] == '0 || imgSize < DW'(K) || imgSize > DW'(MAX_IMG))
                    stateNext = DONE;
                else
                    stateNext = RD_FILT;
            end
            RD_FILT: if (enable && loadEnable && dmaDone) begin
                loadWeights = 1'b1;
                stateNext   = LD_IMG;
            end
            LD_IMG: if (enable && loadImageEnable && loadImageDone) begin
                outAddrNext = curImg + imgSize * imgSize;
                rowNext     = '0;
                colNext     = '0;
                tapNext     = '0;
                tapRowNext  = '0;
                tapColNext  = '0;
                macClear    = 1'b1;
                stateNext   = MAC;
            end
            MAC: if (enable) begin
                macStep = 1'b1;
                if (tap == TAP_W'(KK - 1)) begin
                    tapNext    = '0;
                    tapRowNext = '0;
                    tapColNext = '0;
                    stateNext  = WR;
                end else begin
                    tapNext = tap + TAP_W'(1);
                    if (tapCol == SUB_W'(K - 1)) begin
                        tapColNext = '0;
                        tapRowNext = tapRow + SUB_W'(1);
                    end else begin
                        tapColNext = tapCol + SUB_W'(1);
                    end
                end
            end
            WR: if (enable && writeEnable && dmaDone) begin
                macClear = 1'b1;
                if (col == lastIdx) begin
                    colNext = '0;
                    if (row == lastIdx) begin
                        stateNext = NEXT;
                    end else begin
                        rowNext   = row + DW'(1);
                        stateNext = MAC;
                    end
                end else begin
                    colNext   = col + DW'(1);
                    stateNext = MAC;
                end
            end
            NEXT: if (enable) begin
                layerIdxNext = layerIdx + DW'(1);
                curImgNext   = outAddr;
                imgSizeNext  = outSide;
                if (layerIdx + DW'(1) == numLayers || outSide < DW'(K))
                    stateNext = DONE;
                else
                    stateNext = RD_FILT;
            end
            DONE: if (!enable) begin
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase

        loadEnableNext      = enable && (stateNext == RD_HDR || stateNext == RD_FILT);
        writeEnableNext     = enable && (stateNext == WR);
        loadImageEnableNext = enable && (stateNext == LD_IMG);
        doneNext            = (stateNext == DONE);
        dmaAddressNext      = dmaAddress;
        dmaInputNext        = dmaInput;
        loadImgAddressNext  = loadImgAddress;

        case (stateNext)
            RD_HDR:  dmaAddressNext = orgLayerAddress + DW'(HDR_OFFSET);
            RD_FILT: dmaAddressNext = orgLayerAddress + DW'(FILT_OFFSET) + DW'(KK) * layerIdxNext;
            LD_IMG:  loadImgAddressNext = curImgNext;
            WR: begin
                dmaAddressNext = outAddr + row * outSide + col;
                if (state == MAC)
                    dmaInputNext = pixelResult;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            layerIdx        <= '0;
            numLayers       <= '0;
            curImg          <= '0;
            outAddr         <= '0;
            row             <= '0;
            col             <= '0;
            tap             <= '0;
            tapRow          <= '0;
            tapCol          <= '0;
            imgSize         <= '0;
            dmaEnable       <= 1'b0;
            dmaAddress      <= '0;
            dmaInput        <= '0;
            loadEnable      <= 1'b0;
            writeEnable     <= 1'b0;
            loadImageEnable <= 1'b0;
            loadImgAddress  <= '0;
            done            <= 1'b0;
        end else begin
            state           <= stateNext;
            layerIdx        <= layerIdxNext;
            numLayers       <= numLayersNext;
            curImg          <= curImgNext;
            outAddr         <= outAddrNext;
            row             <= rowNext;
            col             <= colNext;
            tap             <= tapNext;
            tapRow          <= tapRowNext;
            tapCol          <= tapColNext;
            imgSize         <= imgSizeNext;
            dmaEnable       <= loadEnableNext | writeEnableNext;
            dmaAddress      <= dmaAddressNext;
            dmaInput        <= dmaInputNext;
            loadEnable      <= loadEnableNext;
            writeEnable     <= writeEnableNext;
            loadImageEnable <= loadImageEnableNext;
            loadImgAddress  <= loadImgAddressNext;
            done            <= doneNext;
        end
    end

    // Row-major kernel captured from the filter read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            weights <= '{default: '0};
        end else if (loadWeights) begin
            weights <= memFetchResult;
        end
    end

endmodule

// File: tb/tb_cnn_controller.sv
// Self-checking bench: DMA memory and load_block modelled in the bench, results
// compared against a direct convolution model of every layer.
module tb_cnn_controller;
    import cnn_pkg::*;

    localparam int BUDGET = 20000;

    logic                 clk;
    logic                 reset;
    logic                 enable;
    logic [DW-1:0]        orgLayerAddress, orgImgAddress, orgImgSize;
    logic signed [DW-1:0] memFetchResult [KK];
    logic signed [DW-1:0] fetchedImage [MAX_PIX];
    logic [DW-1:0]        loadBlockAddress;
    logic                 dmaDone, loadImageDone;
    logic [DW-1:0]        imgSize, dmaAddress, loadImgAddress;
    logic signed [DW-1:0] dmaInput;
    logic                 dmaEnable, loadEnable, writeEnable, loadImageEnable, done;

    logic signed [15:0] mem [65536];
    int expAddr[$], expData[$], expLdAddr[$], expLdSize[$];
    int wrAddr[$], wrData[$], ldAddr[$], ldSize[$];
    int nChecks, nPass;

    cnn_controller dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .orgLayerAddress  (orgLayerAddress),
        .orgImgAddress    (orgImgAddress),
        .orgImgSize       (orgImgSize),
        .memFetchResult   (memFetchResult),
        .fetchedImage     (fetchedImage),
        .loadBlockAddress (loadBlockAddress),
        .dmaDone          (dmaDone),
        .loadImageDone    (loadImageDone),
        .imgSize          (imgSize),
        .dmaEnable        (dmaEnable),
        .dmaAddress       (dmaAddress),
        .dmaInput         (dmaInput),
        .loadEnable       (loadEnable),
        .writeEnable      (writeEnable),
        .loadImageEnable  (loadImageEnable),
        .loadImgAddress   (loadImgAddress),
        .done             (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        nChecks++;
        if (got == exp) nPass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    // kind: 0 = all 0x0100, 1 = identity kernel, 2 = random
    task automatic set_layers(input int base, input int nL, input int kind);
        mem[16'(base)] = 16'(nL);
        for (int l = 0; l < 3; l++)
            for (int i = 0; i < KK; i++)
                mem[16'(base + 1 + KK * l + i)] = (kind == 0) ? 16'h0100 :
                                                  (kind == 1) ? ((i == 12) ? 16'h0100 : 16'h0000) :
                                                  16'($urandom);
    endtask

    // kind: 0 = all 0x0100, 1 = (index & 127) << 8, 2 = random
    task automatic set_image(input int base, input int side, input int kind);
        for (int i = 0; i < side * side; i++)
            mem[16'(base + i)] = (kind == 0) ? 16'h0100 :
                                 (kind == 1) ? 16'((i & 127) << 8) : 16'($urandom);
    endtask

    // Straight valid convolution per layer; each output image feeds the next layer.
    task automatic build_expected(input int nL, input int layerBase, input int imgBase, input int side0);
        int img[]; int nxt[];
        int side, base, outBase, os, sum;
        shortint q;
        expAddr.delete(); expData.delete(); expLdAddr.delete(); expLdSize.delete();
        if (nL == 0 || side0 < K || side0 > MAX_IMG) return;
        side = side0;
        base = imgBase;
        img = new[side * side];
        for (int i = 0; i < side * side; i++) img[i] = int'(mem[16'(base + i)]);
        for (int l = 0; l < nL; l++) begin
            expLdAddr.push_back(base);
            expLdSize.push_back(side);
            os = side - 4;
            outBase = (base + side * side) & 32'hFFFF;
            nxt = new[os * os];
            for (int r = 0; r < os; r++)
                for (int c = 0; c < os; c++) begin
                    sum = 0;
                    for (int kr = 0; kr < K; kr++)
                        for (int kc = 0; kc < K; kc++)
                            sum += img[(r + kr) * side + c + kc] *
                                   int'(mem[16'(layerBase + 1 + KK * l + kr * K + kc)]);
                    q = shortint'(sum >>> 8);
                    nxt[r * os + c] = int'(q);
                    expAddr.push_back((outBase + r * os + c) & 32'hFFFF);
                    expData.push_back(int'(q) & 32'hFFFF);
                end
            img = nxt;
            base = outBase;
            side = os;
            if (side < K) break;
        end
    endtask

    task automatic run_case(input string name, input int nL, input int side, input int layerBase,
                            input int imgBase, input bit stallMac, input bit stallWr, input int expDoneCyc);
        int cyc, doneCyc, ldCnt, sinceLoad, wrStallCnt, exclBad, dmaBad;
        bit wrStalled;
        build_expected(nL, layerBase, imgBase, side);
        wrAddr.delete(); wrData.delete(); ldAddr.delete(); ldSize.delete();
        reset = 1'b1;
        enable = 1'b0;
        dmaDone = 1'b1;
        loadImageDone = 1'b0;
        orgLayerAddress = 16'(layerBase);
        orgImgAddress = 16'(imgBase);
        orgImgSize = 16'(side);
        repeat (2) @(negedge clk);
        check({name, " rst flags"}, int'({done, dmaEnable, loadEnable, writeEnable, loadImageEnable}), 0);
        check({name, " rst addr"}, int'(dmaAddress) + int'(imgSize) + int'(loadImgAddress), 0);
        for (int i = 0; i < KK; i++) memFetchResult[i] = mem[16'(dmaAddress + 16'(i))];
        reset = 1'b0;
        enable = 1'b1;
        cyc = 0; doneCyc = -1; ldCnt = 0; sinceLoad = -1; wrStallCnt = 0; wrStalled = 0;
        exclBad = 0; dmaBad = 0;
        while (cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check({name, " first loadEnable"}, int'(loadEnable), 1);
                check({name, " first dmaAddress"}, int'(dmaAddress), layerBase);
                check({name, " first done"}, int'(done), 0);
            end
            if (done) begin
                doneCyc = cyc;
                break;
            end
            if (int'(loadEnable) + int'(writeEnable) + int'(loadImageEnable) > 1) exclBad++;
            if (dmaEnable != (loadEnable | writeEnable)) dmaBad++;
            if (sinceLoad >= 0 && sinceLoad < 100) begin
                sinceLoad++;
                if (sinceLoad == 6) enable = 1'b0;
                if (sinceLoad == 8)
                    check({name, " paused requests"},
                          int'({loadEnable, writeEnable, loadImageEnable, dmaEnable}), 0);
                if (sinceLoad == 9) enable = 1'b1;
            end
            if (stallWr && !wrStalled && writeEnable) begin
                dmaDone = 1'b0;
                wrStallCnt = 2;
                wrStalled = 1'b1;
            end else if (wrStallCnt > 0) begin
                wrStallCnt--;
                if (wrStallCnt == 0) dmaDone = 1'b1;
            end
            if (writeEnable && dmaDone && enable) begin
                mem[dmaAddress] = dmaInput;
                wrAddr.push_back(int'(dmaAddress));
                wrData.push_back(int'(dmaInput) & 32'hFFFF);
            end
            if (loadImageDone) begin
                loadImageDone = 1'b0;
            end else if (loadImageEnable) begin
                ldCnt++;
                if (ldCnt == 3) begin
                    ldCnt = 0;
                    for (int i = 0; i < int'(imgSize) * int'(imgSize) && i < MAX_PIX; i++)
                        fetchedImage[i] = mem[16'(loadImgAddress + 16'(i))];
                    loadImageDone = 1'b1;
                    ldAddr.push_back(int'(loadImgAddress));
                    ldSize.push_back(int'(imgSize));
                    if (stallMac && sinceLoad < 0) sinceLoad = 0;
                end
            end
            for (int i = 0; i < KK; i++) memFetchResult[i] = mem[16'(dmaAddress + 16'(i))];
        end
        check({name, " done reached"}, int'(doneCyc > 0), 1);
        if (expDoneCyc > 0) check({name, " done cycle"}, doneCyc, expDoneCyc);
        check({name, " write count"}, wrAddr.size(), expAddr.size());
        for (int i = 0; i < wrAddr.size() && i < expAddr.size(); i++) begin
            check($sformatf("%s wr%0d addr", name, i), wrAddr[i], expAddr[i]);
            check($sformatf("%s wr%0d data", name, i), wrData[i], expData[i]);
        end
        check({name, " load count"}, ldAddr.size(), expLdAddr.size());
        for (int i = 0; i < ldAddr.size() && i < expLdAddr.size(); i++) begin
            check($sformatf("%s ld%0d addr", name, i), ldAddr[i], expLdAddr[i]);
            check($sformatf("%s ld%0d size", name, i), ldSize[i], expLdSize[i]);
        end
        check({name, " exclusive requests"}, exclBad, 0);
        check({name, " dmaEnable"}, dmaBad, 0);
        enable = 1'b0;
        @(negedge clk);
        check({name, " done cleared"}, int'(done), 0);
    endtask

    initial begin
        nChecks = 0;
        nPass = 0;
        reset = 1'b1;
        enable = 1'b0;
        dmaDone = 1'b1;
        loadImageDone = 1'b0;
        loadBlockAddress = '0;
        orgLayerAddress = '0;
        orgImgAddress = '0;
        orgImgSize = '0;
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        for (int i = 0; i < MAX_PIX; i++) fetchedImage[i] = '0;
        for (int i = 0; i < KK; i++) memFetchResult[i] = '0;

        set_layers(0, 1, 0);
        set_image(100, 6, 0);
        run_case("ones", 1, 6, 0, 100, 1'b0, 1'b0, 0);

        set_layers(0, 1, 1);
        set_image(100, 6, 1);
        run_case("identity", 1, 6, 0, 100, 1'b0, 1'b0, 0);

        set_layers(0, 2, 1);
        set_image(100, 10, 1);
        run_case("two layers", 2, 10, 0, 100, 1'b0, 1'b0, 0);

        set_layers(0, 1, 1);
        set_image(100, 6, 1);
        run_case("size4", 1, 4, 0, 100, 1'b0, 1'b0, 2);
        run_case("size33", 1, 33, 0, 100, 1'b0, 1'b0, 2);
        set_layers(0, 0, 1);
        run_case("zero layers", 0, 6, 0, 100, 1'b0, 1'b0, 2);

        set_layers(0, 1, 1);
        set_image(100, 6, 1);
        run_case("stalled", 1, 6, 0, 100, 1'b1, 1'b1, 0);

        for (int n = 0; n < 5; n++) begin
            int nL, side;
            nL = int'($urandom_range(1, 3));
            side = int'($urandom_range(5, 12));
            set_layers(1000, nL, 2);
            set_image(3000, side, 2);
            run_case($sformatf("rand%0d", n), nL, side, 1000, 3000, n[0], n[1], 0);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
